// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: tracks the instructions in flight
// after decode and derives load-use stalls, EX holds, branch flushes and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int  DEPTH      = 3,
  parameter int  LOAD_STAGE = 2,
  parameter int  BR_STAGE   = 1,
  parameter int  CNT_W      = 16,
  localparam int SELW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             ex_hold,
  input  logic             br_taken,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [SELW-1:0]  fwd_a,
  output logic [SELW-1:0]  fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic [2:0] rdy;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } info_t;

  logic [DEPTH-1:0] vld_q, vld_d;
  info_t            info_q [DEPTH];
  info_t            info_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hold_act, flush_act, lu_stall;

  function automatic logic prod_hit(input logic v, input info_t e, input logic [4:0] src);
    return v && e.wr && (e.rd != 5'd0) && (e.rd == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Youngest producer per source decides; its result is usable from EX once it
  // sits at an entry whose index+1 reaches rdy. The last entry writes the regfile
  // before ID reads it, so it never stalls.
  always_comb begin
    logic seen_a, seen_b;
    lu_stall = 1'b0;
    seen_a   = 1'b0;
    seen_b   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!seen_a && id_use_rs1 && prod_hit(vld_q[i], info_q[i], id_rs1)) begin
        seen_a = 1'b1;
        if ((i <= DEPTH - 2) && ((i + 1) < int'(info_q[i].rdy))) lu_stall = 1'b1;
      end
      if (!seen_b && id_use_rs2 && prod_hit(vld_q[i], info_q[i], id_rs2)) begin
        seen_b = 1'b1;
        if ((i <= DEPTH - 2) && ((i + 1) < int'(info_q[i].rdy))) lu_stall = 1'b1;
      end
    end
    lu_stall = lu_stall & id_valid;
  end

  // Descending scan so the youngest matching entry wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (vld_q[0] && prod_hit(vld_q[j], info_q[j], info_q[0].rs1)) fwd_a = SELW'(j);
      if (vld_q[0] && prod_hit(vld_q[j], info_q[j], info_q[0].rs2)) fwd_b = SELW'(j);
    end
  end

  // Hold and flush only act on a real instruction, so an empty tracker keeps
  // every control output low (including while reset is asserted).
  always_comb begin
    hold_act    = ex_hold & vld_q[0];
    flush_act   = br_taken & vld_q[BR_STAGE];
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (flush_act) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if (hold_act) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (lu_stall) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  always_comb begin
    vld_d[0]      = id_valid;
    info_d[0].rd  = id_rd;
    info_d[0].wr  = id_regwrite;
    info_d[0].rdy = id_is_load ? 3'(LOAD_STAGE) : 3'd1;
    info_d[0].rs1 = id_rs1;
    info_d[0].rs2 = id_rs2;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      info_d[k] = info_q[k-1];
    end
    if (flush_act) begin
      // Entries younger than the branch are killed before they advance.
      vld_d[0] = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        if (k <= BR_STAGE) vld_d[k] = 1'b0;
      end
    end else if (hold_act) begin
      vld_d[0]  = vld_q[0];
      info_d[0] = info_q[0];
      vld_d[1]  = 1'b0;
    end else if (lu_stall) begin
      vld_d[0] = 1'b0;
    end
    stall_cnt_d = stall_pc ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = br_taken ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) info_q[k] <= info_d[k];
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a default-parameter instance and a DEPTH=5/LOAD_STAGE=3/CNT_W=3
// instance share stimulus; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_hold, br_taken;

  logic       d3_stall_pc, d3_stall_if_id, d3_bubble_ex, d3_flush_if_id;
  logic [1:0] d3_fwd_a, d3_fwd_b;
  logic [15:0] d3_stall_cnt, d3_flush_cnt;

  logic       d5_stall_pc, d5_stall_if_id, d5_bubble_ex, d5_flush_if_id;
  logic [2:0] d5_fwd_a, d5_fwd_b;
  logic [2:0] d5_stall_cnt, d5_flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_d3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_hold(ex_hold),
    .br_taken(br_taken), .stall_pc(d3_stall_pc), .stall_if_id(d3_stall_if_id),
    .bubble_ex(d3_bubble_ex), .flush_if_id(d3_flush_if_id), .fwd_a(d3_fwd_a),
    .fwd_b(d3_fwd_b), .stall_cnt(d3_stall_cnt), .flush_cnt(d3_flush_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_STAGE(3), .BR_STAGE(1), .CNT_W(3)) u_d5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_hold(ex_hold),
    .br_taken(br_taken), .stall_pc(d5_stall_pc), .stall_if_id(d5_stall_if_id),
    .bubble_ex(d5_bubble_ex), .flush_if_id(d5_flush_if_id), .fwd_a(d5_fwd_a),
    .fwd_b(d5_fwd_b), .stall_cnt(d5_stall_cnt), .flush_cnt(d5_flush_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; id_is_load = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic wr, input logic ld);
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = wr; id_is_load = ld;
  endtask

  task automatic drain();
    idle_id();
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with hold/branch requests asserted: nothing is valid, so all quiet
    reset = 1'b0; idle_id(); ex_hold = 1'b1; br_taken = 1'b1;
    tick(); tick();
    #1;
    check("rst_stall_pc", 32'(d3_stall_pc), 0);
    check("rst_flush",    32'(d3_flush_if_id), 0);
    check("rst_bubble",   32'(d3_bubble_ex), 0);
    check("rst_fwd_a",    32'(d3_fwd_a), 0);
    check("rst_stall_cnt", 32'(d3_stall_cnt), 0);
    check("rst_flush_cnt", 32'(d3_flush_cnt), 0);
    ex_hold = 1'b0; br_taken = 1'b0;
    tick();
    reset = 1'b1;

    // DEPTH=5, LOAD_STAGE=3: x0 never stalls or forwards
    set_id(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x0
    tick();
    set_id(5'd11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);           // add x11,x0,x0
    #1 check("d5_x0_nostall", 32'(d5_stall_pc), 0);
    tick();
    set_id(5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x9
    #1 check("d5_x0_nofwd", 32'(d5_fwd_a), 0);
    tick();
    set_id(5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);           // add x12 (gap)
    tick();
    set_id(5'd13, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);           // add x13,x9,x1
    #1 check("d5_gap1_stall", 32'(d5_stall_pc), 1);
    check("d5_gap1_bubble", 32'(d5_bubble_ex), 1);
    tick();
    #1 check("d5_gap1_release", 32'(d5_stall_pc), 0);
    tick();
    idle_id();
    #1 check("d5_fwd_lw", 32'(d5_fwd_a), 3);
    check("d5_stall_cnt", 32'(d5_stall_cnt), 1);

    // Short asynchronous reset pulse to start from a clean tracker
    reset = 1'b0; #1 reset = 1'b1;

    // Load-use with defaults
    set_id(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x5
    tick();
    set_id(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);            // add x6,x5,x1
    #1 check("lu_stall_pc", 32'(d3_stall_pc), 1);
    check("lu_stall_if_id", 32'(d3_stall_if_id), 1);
    check("lu_bubble", 32'(d3_bubble_ex), 1);
    check("lu_no_flush", 32'(d3_flush_if_id), 0);
    tick();
    #1 check("lu_release", 32'(d3_stall_pc), 0);
    tick();
    idle_id();
    #1 check("lu_fwd_a", 32'(d3_fwd_a), 2);
    check("lu_fwd_b", 32'(d3_fwd_b), 0);
    check("lu_stall_cnt", 32'(d3_stall_cnt), 1);
    drain();

    // ALU-to-ALU forward
    set_id(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);            // add x3
    tick();
    set_id(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);            // sub x4,x3,x3
    #1 check("alu_nostall", 32'(d3_stall_pc), 0);
    tick();
    idle_id();
    #1 check("alu_fwd_a", 32'(d3_fwd_a), 1);
    check("alu_fwd_b", 32'(d3_fwd_b), 1);
    drain();

    // Flush beats hold and a pending load-use stall
    set_id(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);            // beq
    tick();
    set_id(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x5
    tick();
    set_id(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);            // add x6,x5,x1
    br_taken = 1'b1; ex_hold = 1'b1;
    #1 check("fl_flush", 32'(d3_flush_if_id), 1);
    check("fl_bubble", 32'(d3_bubble_ex), 1);
    check("fl_stall_pc", 32'(d3_stall_pc), 0);
    check("fl_stall_if_id", 32'(d3_stall_if_id), 0);
    tick();
    br_taken = 1'b0; ex_hold = 1'b0;
    #1 check("fl_lw_killed", 32'(d3_stall_pc), 0);
    check("fl_flush_cnt", 32'(d3_flush_cnt), 1);
    check("fl_stall_cnt", 32'(d3_stall_cnt), 1);
    tick();
    idle_id();
    #1 check("fl_no_fwd", 32'(d3_fwd_a), 0);
    drain();

    // EX hold for three cycles
    set_id(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);            // add x8
    tick();
    set_id(5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);            // add x7,x8,x0
    tick();
    set_id(5'd10, 5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);           // sub x10,x7,x0
    ex_hold = 1'b1;
    #1 check("hold_c1_stall", 32'(d3_stall_pc), 1);
    check("hold_c1_bubble", 32'(d3_bubble_ex), 0);
    check("hold_c1_fwd", 32'(d3_fwd_a), 1);
    tick();
    #1 check("hold_c2_stall", 32'(d3_stall_pc), 1);
    check("hold_c2_fwd", 32'(d3_fwd_a), 2);
    tick();
    #1 check("hold_c3_stall", 32'(d3_stall_pc), 1);
    check("hold_c3_fwd", 32'(d3_fwd_a), 0);
    tick();
    ex_hold = 1'b0;
    #1 check("hold_end_stall", 32'(d3_stall_pc), 0);
    check("hold_stall_cnt", 32'(d3_stall_cnt), 4);
    tick();
    idle_id();
    #1 check("hold_x7_e1", 32'(d3_fwd_a), 1);
    drain();

    // Reset asserted in the middle of a hold
    set_id(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle_id();
    ex_hold = 1'b1;
    #1 check("rh_pre_stall", 32'(d3_stall_pc), 1);
    reset = 1'b0;
    #1 check("rh_stall_pc", 32'(d3_stall_pc), 0);
    check("rh_stall_if_id", 32'(d3_stall_if_id), 0);
    check("rh_bubble", 32'(d3_bubble_ex), 0);
    check("rh_flush", 32'(d3_flush_if_id), 0);
    check("rh_stall_cnt", 32'(d3_stall_cnt), 0);
    check("rh_flush_cnt", 32'(d3_flush_cnt), 0);
    check("rh_d5_stall_cnt", 32'(d5_stall_cnt), 0);
    tick();
    #1 check("rh_held_stall", 32'(d3_stall_pc), 0);
    ex_hold = 1'b0;
    reset = 1'b1;
    set_id(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle_id();
    #1 check("rh_after_fwd", 32'(d3_fwd_a), 1);
    check("rh_after_cnt", 32'(d3_stall_cnt), 0);

    // Counter saturation on the 3-bit instance
    br_taken = 1'b1;
    repeat (9) tick();
    br_taken = 1'b0;
    #1 check("sat_d3_flush_cnt", 32'(d3_flush_cnt), 9);
    check("sat_d5_flush_cnt", 32'(d5_flush_cnt), 7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
